// File: rtl/mult32s_share_arbiter_if.sv
// Operand request / product response bundle for mult32s_share_arbiter.
// master: client side (drives operands, consumes responses).
// slave : arbiter side.
interface mult32s_share_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [63:0]           rsp_product;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product
    );
endinterface

// File: rtl/mult32s_share_arbiter.sv
// Shares one registered 32x32 signed multiplier between NUM_REQ requesters.
// Round-robin issue into a 2-stage pipeline, results returned through a
// credit-protected FIFO tagged with the requester index.
// Define MULT32S_SHARE_FIXED_PRIO_EN for fixed priority (lowest index wins,
// no rotating pointer).
module mult32s_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    mult32s_share_arbiter_if.slave        bus,
    output logic                          busy
);
    localparam int IDW  = $clog2(NUM_REQ);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int FCW  = $clog2(FIFO_DEPTH + 1);
    localparam int CNTW = $clog2(FIFO_DEPTH + 3);

`ifndef MULT32S_SHARE_FIXED_PRIO_EN
    logic [IDW-1:0]     ptr_q, ptr_d;
`endif
    logic               v1_q, v1_d;
    logic [31:0]        a1_q, a1_d, b1_q, b1_d;
    logic [IDW-1:0]     id1_q, id1_d;
    logic               v2_q, v2_d;
    logic [63:0]        prod2_q, prod2_d;
    logic [IDW-1:0]     id2_q, id2_d;
    logic [IDW+63:0]    mem_q [FIFO_DEPTH];
    logic [IDW+63:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0]     count_q, count_d;

    logic [CNTW-1:0]    cnt;
    logic               issue_ok;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     gnt_id;
    logic               gnt_any;
    logic               accept;
    logic               pop;
    logic [IDW+63:0]    head;
    logic signed [63:0] a_ext, b_ext;

    // Credits from registered state only; a same-cycle pop frees nothing.
    always_comb begin
        cnt      = CNTW'(v1_q) + CNTW'(v2_q) + CNTW'(count_q);
        issue_ok = !rst && (cnt < CNTW'(FIFO_DEPTH));
    end

    // Pick the first valid requester from the scan start, gate by credit.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        grant   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef MULT32S_SHARE_FIXED_PRIO_EN
            idx = k;
`else
            idx = (32'(ptr_q) + k) % NUM_REQ;
`endif
            if (!gnt_any && bus.req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
        if (issue_ok && gnt_any) begin
            grant[gnt_id] = 1'b1;
        end
        accept        = |grant;
        bus.req_ready = grant;
    end

`ifndef MULT32S_SHARE_FIXED_PRIO_EN
    // Next scan starts just past the winner; hold when nothing accepted.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end
`endif

    // Stage 1 captures the winner's operands; stage 2 forms the full product.
    always_comb begin
        v1_d  = accept;
        a1_d  = a1_q;
        b1_d  = b1_q;
        id1_d = id1_q;
        if (accept) begin
            a1_d  = bus.req_a[32*gnt_id +: 32];
            b1_d  = bus.req_b[32*gnt_id +: 32];
            id1_d = gnt_id;
        end
        // Sign-extend to 64 bits so the low 64 product bits are exact.
        a_ext   = {{32{a1_q[31]}}, a1_q};
        b_ext   = {{32{b1_q[31]}}, b1_q};
        v2_d    = v1_q;
        prod2_d = a_ext * b_ext;
        id2_d   = id1_q;
    end

    // Result FIFO: push from stage 2, pop on response handshake.
    always_comb begin
        pop      = (count_q != '0) && bus.rsp_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (v2_q) begin
            mem_d[wr_ptr_q] = {id2_q, prod2_q};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({v2_q, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Response port shows the head, zero when empty.
    always_comb begin
        head            = mem_q[rd_ptr_q];
        bus.rsp_valid   = (count_q != '0);
        bus.rsp_id      = bus.rsp_valid ? head[IDW+63:64] : '0;
        bus.rsp_product = bus.rsp_valid ? head[63:0] : '0;
        busy            = v1_q | v2_q | (count_q != '0);
    end

    // State registers; reset drops in-flight work immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifndef MULT32S_SHARE_FIXED_PRIO_EN
            ptr_q <= '0;
`endif
            v1_q     <= 1'b0;
            a1_q     <= '0;
            b1_q     <= '0;
            id1_q    <= '0;
            v2_q     <= 1'b0;
            prod2_q  <= '0;
            id2_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
`ifndef MULT32S_SHARE_FIXED_PRIO_EN
            ptr_q <= ptr_d;
`endif
            v1_q     <= v1_d;
            a1_q     <= a1_d;
            b1_q     <= b1_d;
            id1_q    <= id1_d;
            v2_q     <= v2_d;
            prod2_q  <= prod2_d;
            id2_q    <= id2_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end
endmodule

// File: tb/tb_mult32s_share_arbiter.sv
// Directed bench for mult32s_share_arbiter with a response scoreboard.
module tb_mult32s_share_arbiter;
    localparam int NREQ   = 4;
    localparam int FDEPTH = 4;

    typedef struct {
        logic [7:0]  id;
        logic [63:0] prod;
    } sb_t;

    logic clk;
    logic rst;
    logic busy;
    int   n_assert = 0;
    int   n_fail   = 0;
    sb_t  sb_q[$];
    sb_t  e_mon;
    int   lat;
    int   acc;
    logic [63:0] cexp [3] = '{64'h4000_0000_0000_0000,
                              64'hFFFF_FFFF_8000_0000,
                              64'h3FFF_FFFF_0000_0001};

    mult32s_share_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    mult32s_share_arbiter #(.NUM_REQ(NREQ), .FIFO_DEPTH(FDEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mulref(logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(int i, logic [31:0] a, logic [31:0] b);
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the accept cycle until rsp_valid is seen.
    task automatic measure_latency(output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!bus.rsp_valid && l < 10);
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_wait", 64'(bus.rsp_valid), 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || sb_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_sb_empty", 64'(sb_q.size()), 64'd0);
        chk("drain_busy", 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        sb_q.delete();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e_mon = sb_q.pop_front();
                    chk("rsp_id", 64'(bus.rsp_id), 64'(e_mon.id));
                    chk("rsp_product", bus.rsp_product, e_mon.prod);
                end
            end
            chk("grant_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    e_mon.id   = 8'(i);
                    e_mon.prod = mulref(bus.req_a[32*i +: 32], bus.req_b[32*i +: 32]);
                    sb_q.push_back(e_mon);
                    chk("no_overflow", 64'(sb_q.size() <= FDEPTH), 64'd1);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, with requests asserted to confirm req_ready stays low.
        rst           = 1'b1;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_product", bus.rsp_product, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        tick();
        bus.req_valid = '0;
        rst = 1'b0;

        // Single request from requester 2: 7 * -3.
        tick();
        set_op(2, 32'd7, 32'hFFFF_FFFD);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("single_grant", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = '0;
        measure_latency(lat);
        chk("single_latency", 64'(lat), 64'd3);
        chk("single_id", 64'(bus.rsp_id), 64'd2);
        chk("single_product", bus.rsp_product, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        chk("single_busy_after", 64'(busy), 64'd0);
        chk("single_rsp_valid_after", 64'(bus.rsp_valid), 64'd0);

        // All requesters continuously valid.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'd100);
        bus.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
`ifdef MULT32S_SHARE_FIXED_PRIO_EN
            chk("rr_grant", 64'(bus.req_ready), 64'h1);
`else
            chk("rr_grant", 64'(bus.req_ready), 64'd1 << (k % NREQ));
`endif
        end
        tick();
        bus.req_valid = '0;
        wait_idle();

        // Corner operands, back to back from requester 1.
        tick();
        set_op(1, 32'h8000_0000, 32'h8000_0000);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("corner_grant0", 64'(bus.req_ready), 64'h2);
        tick();
        set_op(1, 32'h8000_0000, 32'd1);
        @(negedge clk);
        chk("corner_grant1", 64'(bus.req_ready), 64'h2);
        tick();
        set_op(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        @(negedge clk);
        chk("corner_grant2", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = '0;
        for (int j = 0; j < 3; j++) begin
            wait_rsp();
            chk("corner_product", bus.rsp_product, cexp[j]);
        end
        wait_idle();

        // Backpressure: only FIFO_DEPTH accepts, head stable, then restart.
        tick();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(1000 * i + 5), -32'(i + 2));
        bus.req_valid = '1;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.req_ready != '0) acc++;
            if (bus.rsp_valid && sb_q.size() != 0) begin
                chk("bp_head_id", 64'(bus.rsp_id), 64'(sb_q[0].id));
                chk("bp_head_product", bus.rsp_product, sb_q[0].prod);
            end
        end
        chk("bp_accepts", 64'(acc), 64'(FDEPTH));
        chk("bp_stalled", 64'(bus.req_ready), 64'd0);
        tick();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_same_cycle_credit", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("bp_restart", 64'(bus.req_ready != '0), 64'd1);
        repeat (3) @(negedge clk);
        tick();
        bus.req_valid = '0;
        wait_idle();

        // Reset with two ops in the pipeline and one in the FIFO.
        tick();
        bus.rsp_ready = 1'b0;
        set_op(3, 32'd11, 32'd13);
        bus.req_valid = 4'b1000;
        @(negedge clk);
        chk("mid_grant0", 64'(bus.req_ready), 64'h8);
        tick();
        set_op(3, -32'd5, 32'd9);
        @(negedge clk);
        chk("mid_grant1", 64'(bus.req_ready), 64'h8);
        tick();
        set_op(3, 32'd123456, -32'd654321);
        @(negedge clk);
        chk("mid_grant2", 64'(bus.req_ready), 64'h8);
        tick();
        bus.req_valid = '0;
        #2;
        chk("mid_pre_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("mid_pre_busy", 64'(busy), 64'd1);
        bus.req_valid = '1;
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("mid_rst_rsp_product", bus.rsp_product, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mid_no_stale_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        tick();
        set_op(1, -32'd1000, 32'd1000);
        set_op(2, 32'd2, 32'd2);
        bus.req_valid = 4'b0110;
        @(negedge clk);
        chk("post_rst_grant", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = '0;
        measure_latency(lat);
        chk("post_rst_latency", 64'(lat), 64'd3);
        chk("post_rst_id", 64'(bus.rsp_id), 64'd1);
        chk("post_rst_product", bus.rsp_product, 64'hFFFF_FFFF_FFF0_BDC0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
